// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and the
// default oversampling ratio used by both uart_rx and uart_tx.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous level input; both stages reset
// to 1 so an idle-high line never looks like an edge coming out of reset.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both stages
    // update together at the edge and form a real two-stage pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver on an OVERSAMPLE x baud clock: mid-bit start validation,
// centre sampling, holding register with valid/read, framing and overrun status.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                   uart_rx_clk,
    input  logic                   uart_rx_rst,
    input  logic                   uart_rx_pin,
    input  logic                   uart_rx_read,
    output logic [UART_DATA_W-1:0] uart_rx_data,
    output logic                   uart_rx_valid,
    output logic                   uart_rx_busy,
    output logic                   uart_rx_frame_err,
    output logic                   uart_rx_overrun
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

    logic rx_s;

    uart_rx_sync u_sync (
        .clk (uart_rx_clk),
        .rst (uart_rx_rst),
        .d   (uart_rx_pin),
        .q   (rx_s)
    );

    uart_state_e            state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [2:0]             bit_idx, bit_idx_nxt;
    logic [UART_DATA_W-1:0] shift, shift_nxt;
    logic [UART_DATA_W-1:0] data, data_nxt;
    logic                   valid, valid_nxt;
    logic                   overrun, overrun_nxt;
    logic                   frame_err, frame_err_nxt;

    always_ff @(posedge uart_rx_clk) begin
        if (uart_rx_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift     <= shift_nxt;
            data      <= data_nxt;
            valid     <= valid_nxt;
            overrun   <= overrun_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path can leave one
        // unassigned and infer a latch.
        state_nxt     = state;
        cnt_nxt       = cnt;
        bit_idx_nxt   = bit_idx;
        shift_nxt     = shift;
        data_nxt      = data;
        valid_nxt     = valid;
        overrun_nxt   = overrun;
        frame_err_nxt = 1'b0;

        if (uart_rx_read) begin
            valid_nxt   = 1'b0;
            overrun_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt   = DATA;
                        bit_idx_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt     = '0;
                    shift_nxt   = {rx_s, shift[UART_DATA_W-1:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        state_nxt = IDLE;
                        // A read in the same cycle frees the register for the new byte.
                        if (!valid || uart_rx_read) begin
                            data_nxt  = shift;
                            valid_nxt = 1'b1;
                        end else begin
                            overrun_nxt = 1'b1;
                        end
                    end else begin
                        state_nxt     = BREAK;
                        frame_err_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign uart_rx_data      = data;
    assign uart_rx_valid     = valid;
    assign uart_rx_busy      = (state != IDLE);
    assign uart_rx_frame_err = frame_err;
    assign uart_rx_overrun   = overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are bit-banged at 16 clk/bit and received
// bytes are checked against a queue of expected values.
module tb_uart_rx;

    localparam int OS = 16;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       pin  = 1'b1;
    logic       read = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_edge = 0;
    int rise_edge = -1;
    int fe_cycles = 0;
    logic valid_d = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .uart_rx_clk       (clk),
        .uart_rx_rst       (rst),
        .uart_rx_pin       (pin),
        .uart_rx_read      (read),
        .uart_rx_data      (data),
        .uart_rx_valid     (valid),
        .uart_rx_busy      (busy),
        .uart_rx_frame_err (frame_err),
        .uart_rx_overrun   (overrun)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err) fe_cycles++;
        if (valid && !valid_d) rise_edge = cyc;
        valid_d = valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives the first n bit-clocks of a frame; read pulses before edge read_k.
    task automatic frame(input logic [7:0] b, input logic stop, input int read_k, input int n);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        start_edge = cyc + 1;
        for (int k = 0; k < n; k++) begin
            pin  = bits[k / OS];
            read = (k == read_k);
            tick(1);
        end
        read = 1'b0;
    endtask

    task automatic expect_byte(input string tag);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %0h expected nothing queued", tag, data);
        end else begin
            checks--;
            check(tag, {24'd0, data}, {24'd0, exp_q.pop_front()});
        end
    endtask

    task automatic do_read();
        read = 1'b1;
        tick(1);
        read = 1'b0;
    endtask

    initial begin
        #1;
        tick(3);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_fe", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        rst = 1'b0;
        tick(5);

        // Plain byte and latency
        exp_q.push_back(8'hA5);
        rise_edge = -1;
        frame(8'hA5, 1'b1, -1, 160);
        check("a5_latency", rise_edge - start_edge, 154);
        check("a5_valid", valid, 1'b1);
        check("a5_busy", busy, 1'b0);
        check("a5_fe", fe_cycles, 0);
        expect_byte("a5_data");
        do_read();
        check("a5_read_valid", valid, 1'b0);

        // Short glitch rejected by the start check
        pin = 1'b0;
        tick(4);
        pin = 1'b1;
        tick(20);
        check("glitch_busy", busy, 1'b0);
        check("glitch_valid", valid, 1'b0);
        check("glitch_data", data, 8'hA5);
        check("glitch_fe", fe_cycles, 0);

        // Framing error, line held low, then recovery
        frame(8'h3C, 1'b0, -1, 160);
        tick(24);
        check("fe_pulses", fe_cycles, 1);
        check("fe_valid", valid, 1'b0);
        check("fe_data", data, 8'hA5);
        check("fe_break_busy", busy, 1'b1);
        pin = 1'b1;
        tick(4);
        check("fe_idle_busy", busy, 1'b0);
        exp_q.push_back(8'h81);
        frame(8'h81, 1'b1, -1, 160);
        tick(2);
        check("81_valid", valid, 1'b1);
        expect_byte("81_data");
        do_read();

        // Overrun: second byte discarded
        exp_q.push_back(8'h11);
        frame(8'h11, 1'b1, -1, 160);
        frame(8'h22, 1'b1, -1, 160);
        tick(2);
        check("ovr_valid", valid, 1'b1);
        check("ovr_flag", overrun, 1'b1);
        expect_byte("ovr_data");
        do_read();
        check("ovr_read_valid", valid, 1'b0);
        check("ovr_read_flag", overrun, 1'b0);

        // Read coinciding with STOP acceptance
        exp_q.push_back(8'h55);
        frame(8'h55, 1'b1, -1, 160);
        expect_byte("55_data");
        exp_q.push_back(8'hAA);
        frame(8'hAA, 1'b1, 154, 160);
        tick(2);
        check("aa_valid", valid, 1'b1);
        check("aa_ovr", overrun, 1'b0);
        expect_byte("aa_data");

        // Reset during bit 4 of 0xF0
        frame(8'hF0, 1'b1, -1, 88);
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_data", data, 8'h00);
        check("mid_rst_valid", valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_fe", frame_err, 1'b0);
        check("mid_rst_ovr", overrun, 1'b0);
        rst = 1'b0;
        pin = 1'b1;
        tick(40);
        check("post_rst_busy", busy, 1'b0);
        exp_q.push_back(8'h0F);
        frame(8'h0F, 1'b1, -1, 160);
        tick(2);
        check("0f_valid", valid, 1'b1);
        expect_byte("0f_data");
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
